// File: rtl/hdlc_pkg.sv
// rtl/hdlc_pkg.sv - shared constants, state type and CRC step for the HDLC receive path
//
// Contents:
//   HDLC_FLAG, CRC16_POLY, CRC16_INIT, BODY_BITS  framing and CRC constants
//   hdlc_state_t                                  receiver state (HUNT / OPEN / BODY)
//   crc16_step()                                  one MSB-first CRC-16/CCITT bit update
package hdlc_pkg;

    localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam int          BODY_BITS  = 40;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        OPEN = 2'd1,
        BODY = 2'd2
    } hdlc_state_t;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic bit_in);
        logic fb;
        fb = crc_in[15] ^ bit_in;
        return {crc_in[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/hdlc_deframer_if.sv
// rtl/hdlc_deframer_if.sv - frame output bundle from the deframer to the address-match stage
//
// Signals:
//   frame_vld  one-cycle pulse, good frame on addr/ctrl/data
//   addr/ctrl/data  fields of the last good frame, held until the next frame_vld
//   crc_err, len_err, abort  one-cycle status pulses
// Modports:
//   master  driven by hdlc_deframer
//   slave   consumer side
interface hdlc_deframer_if;

    logic       frame_vld;
    logic [7:0] addr;
    logic [7:0] ctrl;
    logic [7:0] data;
    logic       crc_err;
    logic       len_err;
    logic       abort;

    modport master (
        output frame_vld, addr, ctrl, data, crc_err, len_err, abort
    );

    modport slave (
        input frame_vld, addr, ctrl, data, crc_err, len_err, abort
    );

endinterface

// File: rtl/crc16_serial.sv
// rtl/crc16_serial.sv - bit-serial CRC-16/CCITT accumulator
//
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   clear      restart from CRC16_INIT (combined with bit_en, the bit is folded into the fresh seed)
//   bit_en     fold bit_in into the running CRC this cycle
//   bit_in     next message bit, MSB first
//   crc[15:0]  running remainder
module crc16_serial
    import hdlc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] base;

    assign base = clear ? CRC16_INIT : crc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc <= CRC16_INIT;
        end else if (clear || bit_en) begin
            crc <= bit_en ? crc16_step(base, bit_in) : base;
        end
    end

endmodule

// File: rtl/hdlc_deframer.sv
// rtl/hdlc_deframer.sv - bit-serial HDLC receiver: bit recovery, flag hunt, destuffing, CRC check
//
// Parameters: CLK_HZ, BAUD (bit period DIV = CLK_HZ/BAUD clocks), STATION_ADDR
// Ports:
//   clk   system clock
//   rst   synchronous active-low reset
//   rx    raw asynchronous serial line
//   frm   hdlc_deframer_if.master: frame_vld/addr/ctrl/data plus crc_err/len_err/abort pulses
// Build option: HDLC_ADDR_FILTER_EN drops good frames whose address is not STATION_ADDR.
module hdlc_deframer
    import hdlc_pkg::*;
#(
    parameter int         CLK_HZ       = 25_000_000,
    parameter int         BAUD         = 9600,
    parameter logic [7:0] STATION_ADDR = 8'h01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    hdlc_deframer_if.master frm
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BCNT_MAX = BW'(DIV - 1);
    localparam logic [BW-1:0] BCNT_MID = BW'(DIV / 2);

    // A closing flag leaves its leading 0 and five 1s in the accumulator.
    localparam logic [5:0] FULL_CNT  = 6'(BODY_BITS + 6);
    localparam logic [5:0] EMPTY_CNT = 6'd6;
    localparam logic [5:0] CRC_CNT   = 6'(BODY_BITS - 16);

`ifdef HDLC_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // ---------------- bit recovery ----------------
    logic          rx_m, rx_s, rx_d;
    logic [BW-1:0] bcnt;
    logic          rx_edge;
    logic          sample;
    logic          b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign rx_edge = rx_s ^ rx_d;
    assign b       = rx_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bcnt <= '0;
        end else if (rx_edge || bcnt == BCNT_MAX) begin
            bcnt <= '0;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    assign sample = !rx_edge && (bcnt == BCNT_MID);

    // ---------------- raw bit classification ----------------
    logic [6:0] hist;
    logic [2:0] ones;
    logic [7:0] win;
    logic       is_flag;
    logic       is_seven;
    logic       is_data;

    assign win      = {hist, b};
    assign is_flag  = sample && (win == HDLC_FLAG);
    assign is_seven = sample && b && (ones >= 3'd6);
    // A bit carries data only while fewer than five 1s precede it; after five,
    // a 0 is a stuffed bit and a 1 is part of a flag or abort.
    assign is_data  = sample && !is_flag && (ones < 3'd5);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist <= '0;
            ones <= '0;
        end else if (sample) begin
            hist <= win[6:0];
            if (!b) begin
                ones <= 3'd0;
            end else if (ones != 3'd7) begin
                ones <= ones + 3'd1;
            end
        end
    end

    // ---------------- state machine ----------------
    hdlc_state_t state, state_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            HUNT: if (is_flag) state_n = OPEN;
            OPEN: if (is_data) state_n = BODY;
            BODY: begin
                if (is_flag) begin
                    state_n = OPEN;
                end else if (is_seven) begin
                    state_n = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    // ---------------- evaluation ----------------
    logic [47:0] acc;
    logic [5:0]  cnt;
    logic [15:0] crc_val;
    logic        len_ok;
    logic        empty_body;
    logic        crc_ok;
    logic        addr_ok;
    logic        body_start;
    logic        body_shift;
    logic        crc_en;
    logic        frame_vld_n, crc_err_n, len_err_n, abort_n;

    // The top two accumulator bits are still the cleared zeros when exactly
    // FULL_CNT bits have been shifted in.
    assign len_ok     = (cnt == FULL_CNT) && (acc[47:46] == 2'b00);
    assign empty_body = (cnt == EMPTY_CNT);
    assign crc_ok     = (crc_val == acc[21:6]);
    assign addr_ok    = !FILTER_EN || (acc[45:38] == STATION_ADDR);

    always_comb begin
        frame_vld_n = 1'b0;
        crc_err_n   = 1'b0;
        len_err_n   = 1'b0;
        abort_n     = 1'b0;
        body_start  = 1'b0;
        body_shift  = 1'b0;
        unique case (state)
            OPEN: body_start = is_data;
            BODY: begin
                body_shift = is_data;
                if (is_flag) begin
                    if (len_ok) begin
                        if (crc_ok) begin
                            frame_vld_n = addr_ok;
                        end else begin
                            crc_err_n = 1'b1;
                        end
                    end else if (!empty_body) begin
                        // An empty body is just a repeated flag whose leading 0
                        // opened BODY; it is idle fill, not a length error.
                        len_err_n = 1'b1;
                    end
                end else if (is_seven) begin
                    abort_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign crc_en = body_start || (body_shift && (cnt < CRC_CNT));

    crc16_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (body_start),
        .bit_en (crc_en),
        .bit_in (b),
        .crc    (crc_val)
    );

    // ---------------- datapath and output registers ----------------
    logic       frame_vld_q, crc_err_q, len_err_q, abort_q;
    logic [7:0] addr_q, ctrl_q, data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc         <= '0;
            cnt         <= '0;
            frame_vld_q <= 1'b0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            abort_q     <= 1'b0;
            addr_q      <= '0;
            ctrl_q      <= '0;
            data_q      <= '0;
        end else begin
            frame_vld_q <= frame_vld_n;
            crc_err_q   <= crc_err_n;
            len_err_q   <= len_err_n;
            abort_q     <= abort_n;
            if (frame_vld_n) begin
                addr_q <= acc[45:38];
                ctrl_q <= acc[37:30];
                data_q <= acc[29:22];
            end
            if (body_start) begin
                acc <= {47'd0, b};
                cnt <= 6'd1;
            end else if (body_shift) begin
                acc <= {acc[46:0], b};
                if (cnt != 6'd63) begin
                    cnt <= cnt + 6'd1;
                end
            end
        end
    end

    assign frm.frame_vld = frame_vld_q;
    assign frm.crc_err   = crc_err_q;
    assign frm.len_err   = len_err_q;
    assign frm.abort     = abort_q;
    assign frm.addr      = addr_q;
    assign frm.ctrl      = ctrl_q;
    assign frm.data      = data_q;

endmodule

// File: tb/tb_hdlc_deframer.sv
// tb/tb_hdlc_deframer.sv - scoreboard bench for hdlc_deframer with directed frames
module tb_hdlc_deframer;

    localparam int CLK_HZ = 32;
    localparam int BAUD   = 2;
    localparam int DIV    = CLK_HZ / BAUD;

    localparam logic [3:0] K_VLD   = 4'b0001;
    localparam logic [3:0] K_CRC   = 4'b0010;
    localparam logic [3:0] K_LEN   = 4'b0100;
    localparam logic [3:0] K_ABORT = 4'b1000;

    typedef struct {
        logic [3:0] kind;
        logic [7:0] a;
        logic [7:0] c;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rx;

    hdlc_deframer_if frm_if ();

    hdlc_deframer #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .STATION_ADDR (8'h01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .frm (frm_if)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t e;
    int   ones_tx = 0;
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_c = 8'h00;
    logic [7:0] last_d = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic [7:0]  by [3];
        r = 16'hFFFF;
        by[0] = a;
        by[1] = c;
        by[2] = d;
        for (int k = 0; k < 3; k++) begin
            r = r ^ {by[k], 8'h00};
            for (int j = 0; j < 8; j++) begin
                r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
            end
        end
        return r;
    endfunction

    task automatic send_bit(input logic bv);
        rx = bv;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 7; i >= 0; i--) send_bit(f[i]);
        ones_tx = 0;
    endtask

    task automatic send_stuffed(input logic [7:0] byt);
        for (int i = 7; i >= 0; i--) begin
            send_bit(byt[i]);
            if (byt[i]) begin
                ones_tx++;
                if (ones_tx == 5) begin
                    send_bit(1'b0);
                    ones_tx = 0;
                end
            end else begin
                ones_tx = 0;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d,
                              input logic [15:0] flip);
        logic [15:0] fcs;
        fcs = crc_model(a, c, d) ^ flip;
        send_stuffed(a);
        send_stuffed(c);
        send_stuffed(d);
        send_stuffed(fcs[15:8]);
        send_stuffed(fcs[7:0]);
        send_flag();
    endtask

    task automatic expect_evt(input logic [3:0] kind, input logic [7:0] a, input logic [7:0] c,
                              input logic [7:0] d);
        exp_t x;
        if (kind == K_VLD) begin
            last_a = a;
            last_c = c;
            last_d = d;
        end
        x.kind = kind;
        x.a = last_a;
        x.c = last_c;
        x.d = last_d;
        exp_q.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_frame_vld"}, {31'd0, frm_if.frame_vld}, 32'd0);
        check({tag, "_crc_err"},   {31'd0, frm_if.crc_err},   32'd0);
        check({tag, "_len_err"},   {31'd0, frm_if.len_err},   32'd0);
        check({tag, "_abort"},     {31'd0, frm_if.abort},     32'd0);
        check({tag, "_addr"},      {24'd0, frm_if.addr},      32'd0);
        check({tag, "_ctrl"},      {24'd0, frm_if.ctrl},      32'd0);
        check({tag, "_data"},      {24'd0, frm_if.data},      32'd0);
    endtask

    // Monitor: every status pulse pops one expected event from the scoreboard.
    always @(negedge clk) begin
        logic [3:0] got;
        got = {frm_if.abort, frm_if.len_err, frm_if.crc_err, frm_if.frame_vld};
        if (got != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=%b required=none", got);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {28'd0, got}, {28'd0, e.kind});
                check("frame_fields", {8'd0, frm_if.addr, frm_if.ctrl, frm_if.data},
                      {8'd0, e.a, e.c, e.d});
            end
        end
    end

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        repeat (10) send_bit(1'b1);
        send_flag();

        // basic good frame
        expect_evt(K_VLD, 8'h01, 8'h03, 8'h5A);
        send_frame(8'h01, 8'h03, 8'h5A, 16'h0000);

        // data 0xFF forces a stuffed zero
        expect_evt(K_VLD, 8'h01, 8'h03, 8'hFF);
        send_frame(8'h01, 8'h03, 8'hFF, 16'h0000);

        // one FCS bit flipped
        expect_evt(K_CRC, 8'h00, 8'h00, 8'h00);
        send_frame(8'h01, 8'h03, 8'h5A, 16'h0001);

        // 32-bit body
        expect_evt(K_LEN, 8'h00, 8'h00, 8'h00);
        send_stuffed(8'h01);
        send_stuffed(8'h03);
        send_stuffed(8'h5A);
        send_stuffed(8'h00);
        send_flag();

        // abort mid-body, then recover on a fresh flag
        expect_evt(K_ABORT, 8'h00, 8'h00, 8'h00);
        send_stuffed(8'h01);
        repeat (8) send_bit(1'b1);
        repeat (4) send_bit(1'b1);
        send_flag();
        expect_evt(K_VLD, 8'h01, 8'hC3, 8'h3C);
        send_frame(8'h01, 8'hC3, 8'h3C, 16'h0000);

        // foreign address
`ifndef HDLC_ADDR_FILTER_EN
        expect_evt(K_VLD, 8'h02, 8'h03, 8'h5A);
`endif
        send_frame(8'h02, 8'h03, 8'h5A, 16'h0000);

        // reset in the middle of a body
        send_stuffed(8'h01);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (12) send_bit(1'b1);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdlc_deframer.md
# hdlc_deframer

Bit-serial HDLC receive front end for the RS-485 link. It recovers bit timing from the asynchronous `rx` line and hunts for the 0x7E flag. It deletes stuffed zeros on the fly, assembles a fixed-format frame body and checks its CRC-16. It then presents address, control and data bytes to the downstream address-match / UART-transmit stage with per-frame status pulses.

## Interface
Parameters:
- `CLK_HZ`, 25_000_000, system clock frequency.
- `BAUD`, 9600, line bit rate; `DIV = CLK_HZ/BAUD` (2604 at defaults).
- `STATION_ADDR`, 8'h01, address used by the filter (see Configuration).

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `rx` in 1: raw serial line, asynchronous to `clk`.
- `frame_vld` out 1: one-cycle pulse, good frame available.
- `addr` out 8: address byte of the last good frame.
- `ctrl` out 8: control byte of the last good frame.
- `data` out 8: data byte of the last good frame.
- `crc_err` out 1: one-cycle pulse, closing flag seen with correct length but CRC mismatch.
- `len_err` out 1: one-cycle pulse, closing flag seen with wrong body length.
- `abort` out 1: one-cycle pulse, seven or more consecutive ones seen while in `BODY`.

## Operation
- `rx` passes through a 2-FF synchronizer. Bit counter `bcnt` (0..DIV-1, wraps) resets to 0 on any synchronized edge. A bit is sampled when `bcnt == DIV/2`.
- Bits arrive MSB-first. The frame is: flag, addr, ctrl, data, crc_hi, crc_lo, flag, with 40 body bits after destuffing.
- An 8-bit raw shift register detects the flag (01111110).
- A ones counter deletes the 0 that follows five consecutive 1s.
- Six 1s then a 0 completes a flag. Seven or more 1s is an abort.
- States:
  - `HUNT`: discard bits until a flag is seen, then go to `OPEN`.
  - `OPEN`: between flags. A further flag stays in `OPEN`. Any other completed non-flag bit clears the accumulator, stores that bit as body bit 1 and goes to `BODY`.
  - `BODY`: destuffed bits shift into a 48-bit accumulator; `cnt` saturates at 63.
    - On flag: evaluate, then go to `OPEN`.
    - On abort: pulse `abort`, go to `HUNT`.
- Evaluation:
  - At flag detection the accumulator holds the flag's leading 0 plus five 1s as its 6 newest bits.
  - Valid length is `cnt == 46`; the body is `acc[45:6]`.
  - If `cnt != 46`, pulse `len_err`.
  - Otherwise compute CRC-16/CCITT over body bits 39..16: poly 0x1021, init 0xFFFF, no reflection, no final XOR. Compare the result with body bits 15..0.
  - On mismatch, pulse `crc_err`.
  - On match, load `addr/ctrl/data` from body bits 39..32, 31..24, 23..16 and pulse `frame_vld`.
- `addr/ctrl/data` hold their value until the next `frame_vld`. There is no back-pressure; the consumer must accept each `frame_vld` pulse.
- At most one of `frame_vld`, `crc_err`, `len_err`, `abort` asserts in any cycle.
- Reset mid-frame: at the next clock edge return to `HUNT` with all state and outputs cleared.

## Timing
- Reset values: every output 0, state `HUNT`, `bcnt` 0.
- Synchronizer latency is 2 cycles. Sampling occurs DIV/2 cycles after the last edge.
- Status pulses assert the cycle after the sample that completes the closing flag, then deassert after one cycle.
- The CRC is computed serially as bits arrive in `BODY`. Its result is ready at flag detection, adding no extra latency.
- Back-to-back frames may share one flag: the closing flag opens the next frame.

## Configuration
- `HDLC_ADDR_FILTER_EN` defined: a good frame with `addr != STATION_ADDR` produces no pulse and outputs are not updated.
- Not defined: every good frame pulses `frame_vld`, whatever its address.

## Structure
- `hdlc_pkg` holds:
  - `HDLC_FLAG = 8'h7E`
  - `CRC16_POLY = 16'h1021`
  - `CRC16_INIT = 16'hFFFF`
  - `BODY_BITS = 40`
  - the state enum `HUNT/OPEN/BODY`
- Sub-module `crc16_serial` has ports clk, rst, clear, bit_en, bit_in, crc[15:0]. It performs a one-bit-per-enable CRC update.

## Test plan
- Flag, addr 0x01, ctrl 0x03, data 0x5A, correct CRC from the bench model, flag → one `frame_vld`; outputs 0x01/0x03/0x5A.
- Same frame with data 0xFF; the bench inserts a stuffed 0 after five 1s → `frame_vld` with data 0xFF and no `len_err`.
- Same frame with one CRC bit flipped → `crc_err` pulse only; outputs keep their previous values.
- Body of 32 bits between flags → `len_err` pulse only.
- Eight consecutive 1s mid-body → `abort` pulse. The state goes to `HUNT`, and a following well-formed frame is received correctly.
- addr 0x02 with a valid CRC → no pulse with `HDLC_ADDR_FILTER_EN` defined, `frame_vld` without it. Also drive `rst`=0 mid-frame: all outputs read 0 the next cycle.
